ram_bridge_tx: RTL

UART-side transmitter for the RAM bridge protocol; the sending end of the receiver that loads program/data memory over `uart_rx`.
- Accepts one {address, data} word pair over a valid/ready handshake.
- Frames it as header + 4 address bytes + 4 data bytes, little-endian.
- Serialises the frame as 8N1 UART on a single line.
- Used for memory read-back/debug dumps, and in loopback benches to drive the receive bridge directly.

---
 rtl/ram_bridge_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ram_bridge_tx.sv
// rtl/ram_bridge_tx.sv - RAM bridge UART transmitter: {addr,data} -> HEADER + 8 LE bytes as 8N1
// Optional checksum byte (XOR of payload) enabled by RAM_BRIDGE_TX_CHECKSUM_EN.
module ram_bridge_tx #(
  parameter int         CLOCKS_PER_BAUD = 16,
  parameter logic [7:0] HEADER          = 8'h57
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        tx_out,
  output logic        busy_out
);

  localparam int BAUD_W = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 10;
`else
  localparam int FRAME_BYTES = 9;
`endif
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [3:0]        byte_cnt, byte_n;
  logic              tx_q, tx_n;
  logic [63:0]       hold;
  logic              accept;
  logic [2:0]        pay_idx;
  logic [7:0]        frame_byte;

`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
  logic [7:0] checksum;
  always_comb begin
    checksum = '0;
    for (int i = 0; i < 8; i++) checksum = checksum ^ hold[i*8 +: 8];
  end
`endif

  // Byte 0 is the header, bytes 1..8 walk the hold register low byte first.
  assign pay_idx = 3'(byte_cnt - 4'd1);
  always_comb begin
    frame_byte = 8'hFF;
    if (byte_cnt == 4'd0)
      frame_byte = HEADER;
    else if (byte_cnt <= 4'd8)
      frame_byte = hold[{pay_idx, 3'b000} +: 8];
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
    else
      frame_byte = checksum;
`endif
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    tx_n    = tx_q;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (valid_in) begin
          accept  = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
          baud_n  = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = frame_byte[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
            tx_n  = frame_byte[bit_cnt + 3'd1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          if (byte_cnt == LAST_BYTE) begin
            state_n = IDLE;
            byte_n  = '0;
            tx_n    = 1'b1;
          end else begin
            state_n = START;
            byte_n  = byte_cnt + 4'd1;
            tx_n    = 1'b0;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_q     <= 1'b1;
      hold     <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      tx_q     <= tx_n;
      if (accept) hold <= {data_in, addr_in};
    end
  end

  assign tx_out    = tx_q;
  assign ready_out = (state == IDLE);
  assign busy_out  = ~ready_out;

endmodule
